// File: rtl/elevator_pkg.sv
// elevator_pkg: shared door state encoding and counter widths for the elevator door logic
package elevator_pkg;
    typedef enum logic [1:0] {
        ST_CLOSED  = 2'b00,
        ST_OPENING = 2'b01,
        ST_OPEN    = 2'b10,
        ST_CLOSING = 2'b11
    } door_state_t;
    localparam int TICK_W   = 8;
    localparam int REOPEN_W = 4;
endpackage

// File: rtl/door_sequencer_tick_sync.sv
// tick_sync: brings a slow clock-like signal into the clk domain and emits a 1-clk pulse per rising edge
//   clk, button_reset (async, active-high) | slow_in: asynchronous slow input | tick: registered edge pulse
module tick_sync (
    input  logic clk,
    input  logic button_reset,
    input  logic slow_in,
    output logic tick
);
    // sr[1:0] is the synchronizer, sr[2] holds the previous synced value for edge detection
    logic [2:0] sr;
    always_ff @(posedge clk or posedge button_reset) begin
        if (button_reset) begin
            sr   <= '0;
            tick <= 1'b0;
        end else begin
            sr   <= {sr[1:0], slow_in};
            tick <= sr[1] & ~sr[2];
        end
    end
endmodule

// File: rtl/door_sequencer.sv
// door_sequencer: runs the door open/hold/close sequence from door_clk ticks and grants car motion
//   clk, button_reset (async, active-high)
//   door_clk: slow timing input | open_request, weight_limit_exceeded, obstruction: car/sensor inputs
//   door_state, motor_open, motor_close, door_closed, move_enable, fault: registered outputs
module door_sequencer
    import elevator_pkg::*;
#(
    parameter int OPEN_TICKS  = 2,
    parameter int HOLD_TICKS  = 3,
    parameter int CLOSE_TICKS = 2,
    parameter int MAX_REOPEN  = 3
) (
    input  logic       clk,
    input  logic       button_reset,
    input  logic       door_clk,
    input  logic       open_request,
    input  logic       weight_limit_exceeded,
    input  logic       obstruction,
    output logic [1:0] door_state,
    output logic       motor_open,
    output logic       motor_close,
    output logic       door_closed,
    output logic       move_enable,
    output logic       fault
);
    localparam logic [TICK_W-1:0]   OPEN_LAST  = TICK_W'(OPEN_TICKS - 1);
    localparam logic [TICK_W-1:0]   HOLD_LAST  = TICK_W'(HOLD_TICKS - 1);
    localparam logic [TICK_W-1:0]   CLOSE_LAST = TICK_W'(CLOSE_TICKS - 1);
    localparam logic [REOPEN_W-1:0] REOPEN_MAX = REOPEN_W'(MAX_REOPEN);

    door_state_t          state, state_n;
    logic [TICK_W-1:0]    tick_cnt, cnt_n;
    logic [REOPEN_W-1:0]  reopen_cnt, reopen_n;
    logic                 fault_n, tick, hold_block;

    tick_sync u_tick_sync (
        .clk          (clk),
        .button_reset (button_reset),
        .slow_in      (door_clk),
        .tick         (tick)
    );

    assign door_state = state;
    // any of these keeps the door open and restarts the dwell
    assign hold_block = weight_limit_exceeded | obstruction | open_request;

    always_ff @(posedge clk or posedge button_reset) begin
        if (button_reset) begin
            state       <= ST_CLOSED;
            tick_cnt    <= '0;
            reopen_cnt  <= '0;
            fault       <= 1'b0;
            motor_open  <= 1'b0;
            motor_close <= 1'b0;
            door_closed <= 1'b1;
            move_enable <= 1'b1;
        end else begin
            state       <= state_n;
            tick_cnt    <= cnt_n;
            reopen_cnt  <= reopen_n;
            fault       <= fault_n;
            motor_open  <= state_n == ST_OPENING;
            motor_close <= state_n == ST_CLOSING;
            door_closed <= state_n == ST_CLOSED;
            move_enable <= state_n == ST_CLOSED && !open_request;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = tick ? tick_cnt + 1'b1 : tick_cnt;
        reopen_n = reopen_cnt;
        fault_n  = fault;
        case (state)
            ST_CLOSED: begin
                cnt_n = '0;
                if (open_request) state_n = ST_OPENING;
            end
            ST_OPENING: begin
                if (tick && tick_cnt == OPEN_LAST) begin
                    state_n = ST_OPEN;
                    cnt_n   = '0;
                end
            end
            ST_OPEN: begin
                if (hold_block) cnt_n = '0;
                else if (tick && tick_cnt == HOLD_LAST) begin
                    state_n = ST_CLOSING;
                    cnt_n   = '0;
                end
            end
            ST_CLOSING: begin
                // reversal wins over a coincident tick; the reopen count saturates
                if (obstruction || weight_limit_exceeded) begin
                    state_n  = ST_OPENING;
                    cnt_n    = '0;
                    reopen_n = &reopen_cnt ? reopen_cnt : reopen_cnt + 1'b1;
                    if (obstruction && reopen_n >= REOPEN_MAX) fault_n = 1'b1;
                end else if (open_request) begin
                    state_n = ST_OPENING;
                    cnt_n   = '0;
                end else if (tick && tick_cnt == CLOSE_LAST) begin
                    state_n  = ST_CLOSED;
                    cnt_n    = '0;
                    reopen_n = '0;
                    fault_n  = 1'b0;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_door_sequencer.sv
// tb_door_sequencer: table-driven check of the door sequence with a queue of expected output bundles
module tb_door_sequencer;
    logic       clk = 1'b0;
    logic       button_reset = 1'b1;
    logic       door_clk = 1'b0;
    logic       open_request = 1'b0;
    logic       weight_limit_exceeded = 1'b0;
    logic       obstruction = 1'b0;
    logic [1:0] door_state;
    logic       motor_open, motor_close, door_closed, move_enable, fault;
    int         errors = 0;
    int         checks = 0;

    // bundle order: {door_state, motor_open, motor_close, door_closed, move_enable, fault}
    localparam logic [6:0] E_CL  = 7'b00_0_0_1_1_0;
    localparam logic [6:0] E_OPG = 7'b01_1_0_0_0_0;
    localparam logic [6:0] E_OPN = 7'b10_0_0_0_0_0;
    localparam logic [6:0] E_CLG = 7'b11_0_1_0_0_0;

    typedef struct {
        logic       req;
        logic       wle;
        logic       obs;
        int         nt;
        logic [6:0] exp;
        string      name;
    } vec_t;

    vec_t       vecs[$];
    logic [6:0] sb[$];

    always #5 clk = ~clk;

    door_sequencer dut (
        .clk                   (clk),
        .button_reset          (button_reset),
        .door_clk              (door_clk),
        .open_request          (open_request),
        .weight_limit_exceeded (weight_limit_exceeded),
        .obstruction           (obstruction),
        .door_state            (door_state),
        .motor_open            (motor_open),
        .motor_close           (motor_close),
        .door_closed           (door_closed),
        .move_enable           (move_enable),
        .fault                 (fault)
    );

    task automatic check(input string name, input logic [6:0] exp);
        logic [6:0] got;
        got = {door_state, motor_open, motor_close, door_closed, move_enable, fault};
        checks++;
        if (got !== exp || (motor_open && motor_close)) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, got, exp);
        end
    endtask

    task automatic tick_pulse();
        door_clk = 1'b1;
        repeat (4) @(posedge clk);
        door_clk = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    // drive inputs, queue the expectation, advance one clk or nt door_clk periods, then compare
    task automatic run(input vec_t v);
        open_request          = v.req;
        weight_limit_exceeded = v.wle;
        obstruction           = v.obs;
        sb.push_back(v.exp);
        if (v.nt == 0) @(posedge clk);
        else repeat (v.nt) tick_pulse();
        #1;
        check(v.name, sb.pop_front());
    endtask

    function automatic vec_t mk(input logic req, input logic wle, input logic obs, input int nt,
                                input logic [6:0] exp, input string name);
        vec_t v;
        v.req = req; v.wle = wle; v.obs = obs; v.nt = nt; v.exp = exp; v.name = name;
        return v;
    endfunction

    initial begin
        vecs.push_back(mk(0, 0, 0, 2, E_CL,      "idle_ticks"));
        vecs.push_back(mk(1, 0, 0, 0, E_OPG,     "req_opening"));
        vecs.push_back(mk(0, 0, 0, 1, E_OPG,     "opening_t1"));
        vecs.push_back(mk(0, 0, 0, 1, E_OPN,     "open_t2"));
        vecs.push_back(mk(0, 0, 0, 2, E_OPN,     "hold_t2"));
        vecs.push_back(mk(0, 0, 0, 1, E_CLG,     "closing"));
        vecs.push_back(mk(0, 0, 0, 1, E_CLG,     "closing_t1"));
        vecs.push_back(mk(0, 0, 0, 1, E_CL,      "closed"));
        vecs.push_back(mk(1, 0, 0, 0, E_OPG,     "w_opening"));
        vecs.push_back(mk(0, 0, 0, 0, E_OPG,     "stall_opening"));
        vecs.push_back(mk(0, 0, 0, 2, E_OPN,     "w_open"));
        vecs.push_back(mk(0, 1, 0, 5, E_OPN,     "overload_hold"));
        vecs.push_back(mk(0, 0, 0, 2, E_OPN,     "release_t2"));
        vecs.push_back(mk(0, 0, 0, 1, E_CLG,     "release_t3"));
        vecs.push_back(mk(0, 0, 1, 0, E_OPG,     "rev1"));
        vecs.push_back(mk(0, 0, 0, 2, E_OPN,     "rev1_open"));
        vecs.push_back(mk(0, 0, 0, 3, E_CLG,     "rev1_closing"));
        vecs.push_back(mk(0, 0, 1, 0, E_OPG,     "rev2"));
        vecs.push_back(mk(0, 0, 0, 2, E_OPN,     "rev2_open"));
        vecs.push_back(mk(0, 0, 0, 3, E_CLG,     "rev2_closing"));
        vecs.push_back(mk(0, 0, 1, 0, E_OPG | 1, "rev3_fault"));
        vecs.push_back(mk(0, 0, 1, 2, E_OPN | 1, "fault_open"));
        vecs.push_back(mk(0, 0, 1, 2, E_OPN | 1, "fault_obs_hold"));
        vecs.push_back(mk(0, 0, 0, 2, E_OPN | 1, "fault_clear_t2"));
        vecs.push_back(mk(0, 0, 0, 1, E_CLG | 1, "fault_closing"));
        vecs.push_back(mk(0, 0, 0, 2, E_CL,      "fault_closed"));
        vecs.push_back(mk(1, 0, 0, 0, E_OPG,     "r_opening"));
        vecs.push_back(mk(0, 0, 0, 2, E_OPN,     "r_open"));
        vecs.push_back(mk(0, 0, 0, 3, E_CLG,     "r_closing"));
        vecs.push_back(mk(1, 0, 0, 0, E_OPG,     "req_reverse"));
        vecs.push_back(mk(1, 0, 0, 2, E_OPN,     "req_open_held"));
        vecs.push_back(mk(1, 0, 0, 4, E_OPN,     "req_blocks_hold"));
        vecs.push_back(mk(0, 0, 0, 3, E_CLG,     "req_release"));
        vecs.push_back(mk(0, 0, 0, 2, E_CL,      "req_closed"));

        repeat (3) @(posedge clk);
        #1;
        check("reset_values", E_CL);
        button_reset = 1'b0;
        foreach (vecs[i]) run(vecs[i]);

        // reset in OPENING while a tick is pending and obstruction is high
        run(mk(1, 0, 0, 0, E_OPG, "pre_reset_opening"));
        open_request = 1'b0;
        obstruction  = 1'b1;
        door_clk     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        button_reset = 1'b1;
        #1;
        check("reset_mid", E_CL);
        door_clk    = 1'b0;
        obstruction = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", E_CL);
        button_reset = 1'b0;
        run(mk(0, 0, 0, 0, E_CL,  "post_reset_idle"));
        run(mk(1, 0, 0, 0, E_OPG, "post_reset_req"));
        open_request = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("no_spurious_tick", E_OPG);
        run(mk(0, 0, 0, 1, E_OPG, "post_reset_t1"));
        run(mk(0, 0, 0, 1, E_OPN, "post_reset_open"));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/door_sequencer.md
Name: door_sequencer

Overview:
- Consumes the slow door timing clock `door_clk` produced by the door-frequency generator. Runs the physical door open/hold/close sequence from its ticks.
- Sits between the car motion controller and the door motor drivers.
- Grants car motion (`move_enable`) only when the door is fully closed.
- Handles weight overload, obstruction reversal and a reversal-limit fault.

Parameters:
- OPEN_TICKS, 2, door_clk ticks spent in OPENING (range 1..255)
- HOLD_TICKS, 3, door_clk ticks door dwells in OPEN (range 1..255)
- CLOSE_TICKS, 2, door_clk ticks spent in CLOSING (range 1..255)
- MAX_REOPEN, 3, consecutive obstruction reversals before fault (range 1..15)

Ports:
- clk  input  1  system clock
- button_reset  input  1  asynchronous, active-high reset
- door_clk  input  1  slow timing clock from generator; treated as asynchronous data, never used as a clock
- open_request  input  1  level/pulse: car stopped at floor, open door
- weight_limit_exceeded  input  1  overload; door must stay open
- obstruction  input  1  beam-break sensor, active-high
- door_state  output  2  00 CLOSED, 01 OPENING, 10 OPEN, 11 CLOSING
- motor_open  output  1  drive door open
- motor_close  output  1  drive door closed
- door_closed  output  1  door fully closed
- move_enable  output  1  car may move
- fault  output  1  reversal limit reached

Behaviour:
- Reset is clocked by clk, with asynchronous assertion on button_reset.
  - Reset values: state CLOSED, all counters 0, door_state=00, motor_open=0, motor_close=0, door_closed=1, move_enable=1, fault=0.
- Tick generation:
  - door_clk passes through a 2-flop synchronizer, then an edge register.
  - tick = 1-clk pulse on each synced rising edge.
  - tick appears 3 clk after the door_clk rising edge.
  - Sync/edge flops reset to 0, so no spurious tick after reset.
- All state and outputs are registered; outputs change the clk after the state transition decision.
- tick_cnt is 8 bits; it is cleared on every state entry and increments on tick.
- CLOSED:
  - open_request=1 -> OPENING on the next clk; no tick needed.
  - Otherwise stay. move_enable=1 only here and only when open_request=0.
- OPENING:
  - motor_open=1.
  - On the tick where tick_cnt reaches OPEN_TICKS-1 -> OPEN.
- OPEN:
  - The hold count advances on tick only when weight_limit_exceeded=0, obstruction=0 and open_request=0.
  - Any of those three inputs high clears the hold count.
  - Hold count reaching HOLD_TICKS-1 on a tick -> CLOSING.
- CLOSING:
  - motor_close=1.
  - obstruction=1 or weight_limit_exceeded=1 -> OPENING on the next clk and reopen_cnt+1.
  - open_request=1 -> OPENING; reopen_cnt unchanged.
  - Reversal has priority over a coincident tick.
  - tick_cnt reaching CLOSE_TICKS-1 on a tick, with no reversal -> CLOSED, and reopen_cnt=0.
- Fault:
  - An obstruction reversal that makes reopen_cnt==MAX_REOPEN sets fault=1 (sticky); the block still goes to OPENING.
  - While fault=1, OPEN exits only when obstruction has been low for a full HOLD_TICKS count.
  - fault clears on the clk the block enters CLOSED, or on reset.
- Door output invariants:
  - motor_open and motor_close are never both 1.
  - door_closed=1 only in CLOSED.
- door_clk stalled: the generator halts on overload, giving no ticks. The block must simply wait in its current state; there is no timeout.
- Reset mid-sequence: immediate return to the reset values, including motors off.

Decomposition:
- Shared package `elevator_pkg` holds:
  - door state encoding constants: ST_CLOSED=2'b00, ST_OPENING=2'b01, ST_OPEN=2'b10, ST_CLOSING=2'b11;
  - tick counter width 8;
  - reopen counter width 4.
- One sub-module: `tick_sync` (2-flop synchronizer plus rising-edge pulse, async reset via button_reset). It is reusable for other slow-clock inputs.
- FSM and counters live in door_sequencer.

Test Plan:
- Reset then idle, toggling door_clk -> door_state=00, door_closed=1, move_enable=1, motors 0 throughout.
- open_request pulse with defaults:
  - OPENING the next clk; OPEN after 2 ticks; CLOSING after 3 more ticks; CLOSED after 2 more.
  - move_enable=0 from the request until CLOSED.
- weight_limit_exceeded high during OPEN for 5 ticks, then low -> stays OPEN; the hold count restarts, and CLOSING follows 3 ticks after release.
- obstruction asserted at the 1st CLOSING tick -> OPENING the next clk, motor_close drops, motor_open rises, reopen_cnt=1.
- 3 consecutive obstruction reversals -> fault=1 on the 3rd. After obstruction clears: OPEN for 3 ticks, then CLOSING, then CLOSED, where fault=0.
- button_reset pulsed during OPENING with a coincident tick and obstruction -> reset values immediately; no tick is counted after release.
